// File: rtl/period_meter.sv
// period_meter: measures rise-to-rise period and high time of a slow input in clk cycles
// Ports: clk, reset (sync, active-high), enable (0 = idle, partial count discarded),
//   sig_in (asynchronous input), period_out/high_out with meas_valid/meas_ready handshake,
//   overrun (sticky, a result was dropped), no_signal (no rising edge within TIMEOUT cycles).
// Build option: define PERIOD_METER_AVG_EN to present the truncated average of every 4 captures.
module period_meter #(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             overrun,
  output logic             no_signal
);
  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic s, s_d, rise, timeout, capture, present;
  logic [CNT_W-1:0] period_cnt, high_cnt, res_p, res_h;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  // period_cnt doubles as the ARM wait counter, so one compare covers both timeouts
  assign timeout = enable && state != IDLE && !rise && period_cnt == CNT_W'(TIMEOUT);
  assign capture = enable && state == MEAS && rise;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    state_nx = !enable ? IDLE : state == IDLE ? ARM : rise ? MEAS : timeout ? ARM : state;
  end
  // the closing rise of one period reloads the counters as the opening rise of the next
  always_ff @(posedge clk) begin
    if (reset || !enable || state == IDLE || timeout) begin
      period_cnt <= '0;
      high_cnt <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt <= CNT_W'(1);
    end else begin
      period_cnt <= period_cnt + CNT_W'(1);
      high_cnt <= state == MEAS ? high_cnt + CNT_W'(s) : '0;
    end
  end
`ifdef PERIOD_METER_AVG_EN
  logic [CNT_W+1:0] acc_p, acc_h, sum_p, sum_h;
  logic [1:0] phase;
  assign sum_p = acc_p + {2'b00, period_cnt};
  assign sum_h = acc_h + {2'b00, high_cnt};
  assign present = capture && phase == 2'd3;
  assign res_p = sum_p[CNT_W+1:2];
  assign res_h = sum_h[CNT_W+1:2];
  always_ff @(posedge clk) begin
    if (reset || !enable || timeout) begin
      acc_p <= '0;
      acc_h <= '0;
      phase <= '0;
    end else if (capture) begin
      acc_p <= present ? '0 : sum_p;
      acc_h <= present ? '0 : sum_h;
      phase <= phase + 2'd1;
    end
  end
`else
  assign present = capture;
  assign res_p = period_cnt;
  assign res_h = high_cnt;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
      s_d <= 1'b0;
      period_out <= '0;
      high_out <= '0;
      meas_valid <= 1'b0;
      overrun <= 1'b0;
      no_signal <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sig_in};
      s_d <= s;
      if (timeout) no_signal <= 1'b1;
      else if (enable && state != IDLE && rise) no_signal <= 1'b0;
      if (present && (!meas_valid || meas_ready)) begin
        period_out <= res_p;
        high_out <= res_h;
        meas_valid <= 1'b1;
      end else if (present) overrun <= 1'b1;
      else if (meas_ready) meas_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: self-checking bench for period_meter (cycle model plus directed results)
module tb_period_meter;
  localparam int W = 32, TO = 100, SS = 2;
  logic clk = 0, reset = 1, enable = 0, sig_in = 0, meas_ready = 1;
  logic [W-1:0] period_out, high_out;
  logic meas_valid, overrun, no_signal;
  int checks = 0, failures = 0;
  period_meter #(.CNT_W(W), .TIMEOUT(TO), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .period_out(period_out), .high_out(high_out), .meas_valid(meas_valid),
    .meas_ready(meas_ready), .overrun(overrun), .no_signal(no_signal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [W-1:0] a, input logic [W-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %0d, expected %0d", n, $time, a, e);
    end
  endtask
  // waveform generator: period gen_per, high gen_hi; queued periods are taken at period start
  int gen_per = 10, gen_hi = 5, ph = 0, q[$];
  bit gen_on = 0;
  initial forever begin
    @(negedge clk);
    if (!gen_on) begin
      sig_in = 0;
      ph = 0;
    end else begin
      if (ph == 0 && q.size() > 0) begin
        gen_per = q.pop_front();
        gen_hi = gen_per / 2;
      end
      sig_in = ph < gen_hi;
      ph = ph + 1 >= gen_per ? 0 : ph + 1;
    end
  end
  // model: rise times and high counts from the synchronised input history
  int cyc = 0, ref_c = 0, highs = 0, mode = 0, n_avg = 0;
  longint sum_p = 0, sum_h = 0;
  logic [31:0] hist = 0;
  logic [W-1:0] e_p = 0, e_h = 0;
  logic e_v = 0, e_o = 0, e_n = 0;
  always @(posedge clk) begin
    logic ms, msd, r, cap;
    logic [W-1:0] cp, ch;
    ms = hist[SS-1];
    msd = hist[SS];
    r = ms & ~msd;
    cap = 0;
    cp = 0;
    ch = 0;
    if (reset) begin
      hist = 0; mode = 0; e_p = 0; e_h = 0; e_v = 0; e_o = 0; e_n = 0;
      n_avg = 0; sum_p = 0; sum_h = 0;
    end else begin
      hist = {hist[30:0], sig_in};
      if (!enable) begin
        mode = 0; n_avg = 0; sum_p = 0; sum_h = 0;
      end else if (mode == 0) begin
        mode = 1;
        ref_c = cyc + 1;
      end else if (r) begin
        if (mode == 2) begin
          cap = 1;
          cp = W'(cyc - ref_c);
          ch = W'(highs);
        end
        mode = 2; ref_c = cyc; highs = 1; e_n = 0;
      end else if (cyc - ref_c == TO) begin
        e_n = 1; mode = 1; ref_c = cyc + 1; n_avg = 0; sum_p = 0; sum_h = 0;
      end else highs += int'(ms);
`ifdef PERIOD_METER_AVG_EN
      if (cap) begin
        sum_p += cp; sum_h += ch; n_avg++;
        cap = n_avg == 4;
        if (cap) begin
          cp = W'(sum_p / 4); ch = W'(sum_h / 4);
          n_avg = 0; sum_p = 0; sum_h = 0;
        end
      end
`endif
      if (cap) begin
        if (!e_v || meas_ready) begin
          e_p = cp; e_h = ch; e_v = 1;
        end else e_o = 1;
      end else if (e_v && meas_ready) e_v = 0;
    end
    cyc++;
  end
  always @(negedge clk) begin
    chk("m_valid", meas_valid, e_v);
    chk("m_period", period_out, e_p);
    chk("m_high", high_out, e_h);
    chk("m_overrun", overrun, e_o);
    chk("m_no_signal", no_signal, e_n);
  end
  task automatic wait_valid(input string n, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (meas_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: meas_valid never seen within 300 cycles", n);
    end
  endtask
  task automatic expect_res(input string n, input int p, input int h);
    bit ok;
    wait_valid(n, ok);
    if (ok) begin
      chk({n, "_period"}, period_out, W'(p));
      chk({n, "_high"}, high_out, W'(h));
    end
  endtask
  task automatic skip_res(input int k);
    bit ok;
    for (int i = 0; i < k; i++) wait_valid("skip", ok);
  endtask
  initial begin
    bit ok;
    repeat (3) @(negedge clk);
    chk("rst_period", period_out, 0);
    chk("rst_high", high_out, 0);
    chk("rst_valid", meas_valid, 0);
    reset = 0;
    enable = 1;
    @(negedge clk);
`ifdef PERIOD_METER_AVG_EN
    q = '{10, 10, 12, 12, 10};
    gen_on = 1;
    expect_res("avg1", 11, 5);
    expect_res("avg2", 10, 5);
`else
    gen_per = 10; gen_hi = 5; gen_on = 1;
    expect_res("sq1", 10, 5);
    expect_res("sq2", 10, 5);
    chk("sq_overrun", overrun, 0);
    chk("sq_no_signal", no_signal, 0);
    gen_per = 20; gen_hi = 3;
    skip_res(1);
    expect_res("d20", 20, 3);
    gen_per = 7; gen_hi = 6;
    skip_res(2);
    expect_res("d7a", 7, 6);
    expect_res("d7b", 7, 6);
    gen_per = 10; gen_hi = 5;
    skip_res(2);
    wait_valid("bp_first", ok);
    meas_ready = 0;
    repeat (15) @(negedge clk);
    chk("bp_hold_valid", meas_valid, 1);
    chk("bp_hold_period", period_out, 10);
    chk("bp_hold_high", high_out, 5);
    chk("bp_overrun", overrun, 1);
    meas_ready = 1;
    @(negedge clk);
    meas_ready = 0;
    chk("bp_drop_valid", meas_valid, 0);
    expect_res("bp_next", 10, 5);
    meas_ready = 1;
    gen_on = 0;
    for (int i = 0; i < 300 && !no_signal; i++) @(negedge clk);
    chk("to_set", no_signal, 1);
    chk("to_valid", meas_valid, 0);
    gen_on = 1;
    for (int i = 0; i < 50 && no_signal; i++) @(negedge clk);
    chk("to_clear", no_signal, 0);
    expect_res("to_resume", 10, 5);
    repeat (4) @(negedge clk);
    enable = 0;
    repeat (20) @(negedge clk);
    chk("en_valid", meas_valid, 0);
    chk("en_period", period_out, 10);
    chk("en_high", high_out, 5);
    enable = 1;
    expect_res("en_resume", 10, 5);
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mid_rst_period", period_out, 0);
    chk("mid_rst_high", high_out, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_no_signal", no_signal, 0);
    reset = 0;
`endif
    repeat (30) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
Measures a slow input waveform in units of `clk` cycles. It reports the rise-to-rise period and the high time of `sig_in`. It is the counterpart of the clock divider: the divider turns a count into a period, and this block turns a period back into a count. It is used to check divided clocks and external slow signals, and feeds status/display logic through a valid/ready output handshake.

Parameters:
- CNT_W, 32, width of period/high counters and outputs.
- TIMEOUT, 50_000_000, cycles without a rising edge before the signal is declared absent. Must be < 2^CNT_W.
- SYNC_STAGES, 2, number of synchronizer flops on `sig_in` (minimum 2).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  1 = measure; 0 = idle, partial measurement discarded.
- sig_in  input  1  asynchronous signal to measure.
- period_out  output  CNT_W  clk cycles between consecutive rising edges.
- high_out  output  CNT_W  clk cycles `sig_in` was high within that period.
- meas_valid  output  1  result available.
- meas_ready  input  1  consumer accepts result.
- overrun  output  1  sticky; a result was dropped.
- no_signal  output  1  timeout occurred since the last rising edge.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`.
- Reset values:
  - Synchronizer and edge-detect flops: 0.
  - State: IDLE.
  - Counters, `period_out`, `high_out`: 0.
  - `meas_valid`, `overrun`, `no_signal`: 0.
- Reset mid-measurement aborts everything. No result is produced for the aborted period.
- Synchronizer and edge detect:
  - `sig_in` passes through SYNC_STAGES flops; the last stage is `s`. A further flop holds `s_d`.
  - `rise` = `s & ~s_d`; `fall` = `~s & s_d`.
  - Both edges see the same latency, so reported values are unaffected by it.
- FSM states:
  - IDLE: stays while `enable`=0. Goes to ARM when `enable`=1.
  - ARM: waits for the first `rise`. On `rise`: period_cnt<=1, high_cnt<=1, go to MEAS.
  - MEAS:
    - period_cnt increments every cycle.
    - high_cnt increments while `s`=1 and freezes after `fall`.
    - On `rise`: capture period_cnt and high_cnt, then reload both to 1 and stay in MEAS. The closing edge of one period is the opening edge of the next.
- Period arithmetic: with rises at cycles t and t+N, the captured period is N. The high count equals the number of cycles `s`=1 in that window.
- Timeout:
  - In ARM or MEAS, if period_cnt (or the ARM wait counter) reaches TIMEOUT with no `rise`: set `no_signal`=1, discard the partial result, go to ARM.
  - `no_signal` clears on the next `rise`.
  - Counters never wrap, because TIMEOUT < 2^CNT_W.
- `enable`=0 in any state: go to IDLE next cycle and discard partial counts. Outputs, `meas_valid` and flags keep their values.
- Output handshake:
  - On capture, if `meas_valid`=0 or `meas_ready`=1 in the same cycle: load `period_out`/`high_out` and set `meas_valid`=1 on the next cycle.
  - If `meas_valid`=1 and `meas_ready`=0: drop the new result, keep the old values, set `overrun`=1.
  - `overrun` clears only on reset.
  - `meas_valid`=1 with `meas_ready`=1 and no capture in that cycle: `meas_valid`<=0.
  - Outputs are stable while `meas_valid`=1 and `meas_ready`=0.
- Latency: `meas_valid` rises 1 cycle after the `rise` that closes a period. The first result appears at the second detected rising edge after enable.

Optional Feature:
- Macro: PERIOD_METER_AVG_EN.
- When defined:
  - Captured period and high counts accumulate over 4 consecutive periods in CNT_W+2-bit sums.
  - Every 4th capture presents sum>>2 (truncating) on the outputs through the same handshake.
  - The accumulator and phase counter clear on reset, timeout, or `enable`=0.
- When undefined: every capture is presented directly. No accumulator logic is present.

Test Plan:
- 1. Square wave, enable=1, ready=1: `sig_in` with period 10, high 5; TIMEOUT=100, CNT_W=32 -> first `meas_valid` 1 cycle after the 2nd synced rise, then one valid pulse every 10 cycles with period_out=10, high_out=5; overrun=0, no_signal=0.
- 2. Duty change: period 20, high 3 -> period_out=20, high_out=3. Then switch to period 7, high 6 -> the first result after the switch reflects the mixed period; subsequent results are 7/6.
- 3. Backpressure: period 10, meas_ready=0 -> the first result (10/5) holds; overrun=1 after the next rise. Raise ready for 1 cycle -> valid drops, then the next capture loads.
- 4. Timeout: TIMEOUT=100, `sig_in` stuck at 0 after a valid period -> no_signal=1 at count 100, no valid. Resume edges -> no_signal=0 on the first rise; a result appears at the second rise.
- 5. Enable/reset abort: drop enable mid-period -> no result, outputs unchanged. Re-enable -> first result only after two fresh rises. Reset mid-MEAS -> all outputs 0 next cycle.
- 6. AVG_EN build: periods 10,10,12,12 with highs 5,5,6,6 -> a single result of 11/5, then nothing until 4 more periods.
